program_loader: RTL and testbench

- Hardware program/data loader that sits between a host word stream and the processor's instruction and data memories.
- Sequences two phases: first instruction memory, then data memory. It then asserts start_signal and monitors the processor's end signal.
- Parametrised successor to the fixed 32-bit, bench-driven load flow.
- Adds depth checking, word counting, an explicit valid/ready handshake and an optional auto-start.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/loader_region_ctr.sv | 60 ++++++
 rtl/program_loader.sv | 171 +++++++++++++++++
 tb/tb_program_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the program loader.
//   - loader_state_e : FSM state enumeration; the encodings are visible on the debug port.
//   - addr_w()       : address width for a memory depth (clog2, never less than 1).
// Optional build macro used by the top: LOADER_CHECKSUM_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        StLoadI  = 3'd0,
        StLoadD  = 3'd1,
        StWaitGo = 3'd2,
        StRun    = 3'd3,
        StDone   = 3'd4,
        StErr    = 3'd5
    } loader_state_e;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/loader_region_ctr.sv
// loader_region_ctr: write counter for one memory region.
// Counts words written into the region and produces a registered write strobe whose address
// is the count before the increment (1-cycle write latency).
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   inc_i   write one word this cycle (caller guarantees the region is not full)
//   we_o    registered write strobe
//   addr_o  registered write address
//   size_o  number of words written so far (0..DEPTH)
//   full_o  size_o == DEPTH
module loader_region_ctr
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = addr_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [AW:0]   size_o,
    output logic          full_o
);

    localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   size_q, size_d;

    always_comb begin
        we_d   = inc_i;
        addr_d = addr_q;
        size_d = size_q;
        if (inc_i) begin
            addr_d = size_q[AW-1:0];
            size_d = size_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            size_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            size_q <= size_d;
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign size_o = size_q;
    assign full_o = (size_q == DepthW);

endmodule

// File: rtl/program_loader.sv
// program_loader: streams a host word sequence into instruction memory, then data memory,
// then starts the processor and waits for its end signal.
// Ports:
//   clk, reset (async, active-low)
//   s_valid/s_ready/s_data/s_last : input word stream; s_last closes the current region
//   go           : manual start when AUTO_START=0
//   proc_end     : processor end signal, honoured only in RUN
//   imem_we/imem_addr, dmem_we/dmem_addr, mem_wdata : registered memory write port
//   start_signal : processor run enable
//   prog_size/data_size : words loaded per region
//   busy, err (sticky), state (debug)
// Optional macro LOADER_CHECKSUM_EN adds chk_expected/chk_sum: the running sum of accepted
// words must match chk_expected when leaving data load, otherwise the loader errors out.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter bit          AUTO_START = 1'b1,
    localparam int unsigned IA_W      = addr_w(IMEM_DEPTH),
    localparam int unsigned DA_W      = addr_w(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              go,
    input  logic              proc_end,
    output logic              imem_we,
    output logic [IA_W-1:0]   imem_addr,
    output logic              dmem_we,
    output logic [DA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              start_signal,
    output logic [IA_W:0]     prog_size,
    output logic [DA_W:0]     data_size,
    output logic              busy,
    output logic              err,
    output logic [2:0]        state
`ifdef LOADER_CHECKSUM_EN
   ,input  logic [DATA_W-1:0] chk_expected,
    output logic [DATA_W-1:0] chk_sum
`endif
);

    loader_state_e     state_q, state_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              accept;
    logic              i_inc, d_inc, i_full, d_full;
    logic              chk_ok;

    assign s_ready = (state_q == StLoadI) || (state_q == StLoadD);
    assign accept  = s_valid && s_ready;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d, sum_next;

    assign sum_next = sum_q + s_data;
    assign sum_d    = accept ? sum_next : sum_q;
    // Compared against the sum including the word being accepted right now.
    assign chk_ok   = (sum_next == chk_expected);
    assign chk_sum  = sum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sum_q <= '0;
        else        sum_q <= sum_d;
    end
`else
    assign chk_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        i_inc   = 1'b0;
        d_inc   = 1'b0;
        unique case (state_q)
            StLoadI: begin
                if (accept) begin
                    if (i_full) begin
                        // Overflowing word is dropped, not written.
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        i_inc   = 1'b1;
                        wdata_d = s_data;
                        if (s_last) state_d = StLoadD;
                    end
                end
            end
            StLoadD: begin
                if (accept) begin
                    if (d_full) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        d_inc   = 1'b1;
                        wdata_d = s_data;
                        if (s_last) begin
                            if (!chk_ok) begin
                                state_d = StErr;
                                err_d   = 1'b1;
                            end else begin
                                state_d = AUTO_START ? StRun : StWaitGo;
                            end
                        end
                    end
                end
            end
            StWaitGo: if (go)       state_d = StRun;
            StRun:    if (proc_end) state_d = StDone;
            default:  ;  // DONE and ERR hold until reset
        endcase
        // Registered from next state so it rises on the first RUN cycle and falls with DONE.
        start_d = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StLoadI;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            start_q <= start_d;
            wdata_q <= wdata_d;
        end
    end

    loader_region_ctr #(
        .DEPTH (IMEM_DEPTH),
        .AW    (IA_W)
    ) u_imem_ctr (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (i_inc),
        .we_o   (imem_we),
        .addr_o (imem_addr),
        .size_o (prog_size),
        .full_o (i_full)
    );

    loader_region_ctr #(
        .DEPTH (DMEM_DEPTH),
        .AW    (DA_W)
    ) u_dmem_ctr (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (d_inc),
        .we_o   (dmem_we),
        .addr_o (dmem_addr),
        .size_o (data_size),
        .full_o (d_full)
    );

    assign mem_wdata    = wdata_q;
    assign start_signal = start_q;
    assign err          = err_q;
    assign state        = state_q;
    assign busy         = (state_q == StLoadI) || (state_q == StLoadD) ||
                          (state_q == StWaitGo) || (state_q == StRun);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader.
// dut_a: 32/32-word regions, auto-start. dut_b: 4/4-word regions, manual start (go).
// Build with LOADER_CHECKSUM_EN defined to also exercise the checksum ports.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut_a signals
    logic        a_valid = 0, a_last = 0, a_go = 0, a_end = 0;
    logic [31:0] a_data = '0;
    logic        a_ready, a_imem_we, a_dmem_we, a_start, a_busy, a_err;
    logic [4:0]  a_imem_addr, a_dmem_addr;
    logic [31:0] a_wdata;
    logic [5:0]  a_psize, a_dsize;
    logic [2:0]  a_state;
    // dut_b signals
    logic        b_valid = 0, b_last = 0, b_go = 0, b_end = 0;
    logic [31:0] b_data = '0;
    logic        b_ready, b_imem_we, b_dmem_we, b_start, b_busy, b_err;
    logic [1:0]  b_imem_addr, b_dmem_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_psize, b_dsize;
    logic [2:0]  b_state;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] a_chk_exp = '0, a_chk_sum, b_chk_exp = '0, b_chk_sum;
`endif

    program_loader #(
        .DATA_W(32), .IMEM_DEPTH(32), .DMEM_DEPTH(32), .AUTO_START(1'b1)
    ) dut_a (
        .clk(clk), .reset(rst_n), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
        .s_last(a_last), .go(a_go), .proc_end(a_end), .imem_we(a_imem_we),
        .imem_addr(a_imem_addr), .dmem_we(a_dmem_we), .dmem_addr(a_dmem_addr),
        .mem_wdata(a_wdata), .start_signal(a_start), .prog_size(a_psize),
        .data_size(a_dsize), .busy(a_busy), .err(a_err), .state(a_state)
`ifdef LOADER_CHECKSUM_EN
       ,.chk_expected(a_chk_exp), .chk_sum(a_chk_sum)
`endif
    );

    program_loader #(
        .DATA_W(32), .IMEM_DEPTH(4), .DMEM_DEPTH(4), .AUTO_START(1'b0)
    ) dut_b (
        .clk(clk), .reset(rst_n), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
        .s_last(b_last), .go(b_go), .proc_end(b_end), .imem_we(b_imem_we),
        .imem_addr(b_imem_addr), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr),
        .mem_wdata(b_wdata), .start_signal(b_start), .prog_size(b_psize),
        .data_size(b_dsize), .busy(b_busy), .err(b_err), .state(b_state)
`ifdef LOADER_CHECKSUM_EN
       ,.chk_expected(b_chk_exp), .chk_sum(b_chk_sum)
`endif
    );

    // Strobe logs, sampled mid-cycle.
    int          a_icnt = 0, a_dcnt = 0, b_icnt = 0, b_dcnt = 0;
    int          a_last_i_cyc = 0, a_first_d_cyc = 0;
    bit          a_both = 0, b_both = 0;
    logic [4:0]  a_iaddr [0:63];
    logic [31:0] a_idata [0:63];
    logic [4:0]  a_daddr [0:63];
    logic [31:0] a_ddata [0:63];
    logic [1:0]  b_iaddr [0:63];
    logic [31:0] b_idata [0:63];

    always @(negedge clk) begin
        if (a_imem_we) begin
            if (a_icnt < 64) begin a_iaddr[a_icnt] = a_imem_addr; a_idata[a_icnt] = a_wdata; end
            a_icnt++;
            a_last_i_cyc = cyc;
        end
        if (a_dmem_we) begin
            if (a_dcnt < 64) begin a_daddr[a_dcnt] = a_dmem_addr; a_ddata[a_dcnt] = a_wdata; end
            if (a_dcnt == 0) a_first_d_cyc = cyc;
            a_dcnt++;
        end
        if (b_imem_we) begin
            if (b_icnt < 64) begin b_iaddr[b_icnt] = b_imem_addr; b_idata[b_icnt] = b_wdata; end
            b_icnt++;
        end
        if (b_dmem_we) b_dcnt++;
        if (a_imem_we && a_dmem_we) a_both = 1;
        if (b_imem_we && b_dmem_we) b_both = 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        a_icnt = 0; a_dcnt = 0; b_icnt = 0; b_dcnt = 0;
        a_both = 0; b_both = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        a_valid = 0; a_last = 0; a_go = 0; a_end = 0; a_data = '0;
        b_valid = 0; b_last = 0; b_go = 0; b_end = 0; b_data = '0;
        step(); step();
        rst_n = 1;
        clear_logs();
    endtask

    task automatic send_a(input logic [31:0] d, input logic l);
        a_valid = 1; a_data = d; a_last = l;
        step();
        a_valid = 0; a_last = 0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic l);
        b_valid = 1; b_data = d; b_last = l;
        step();
        b_valid = 0; b_last = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        step();
        n_cmp++; if (a_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", a_state); end
        n_cmp++; if (a_imem_we !== 1'b0 || a_dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b%b want 00", a_imem_we, a_dmem_we); end
        n_cmp++; if (a_start !== 1'b0 || a_err !== 1'b0) begin n_fail++; $display("FAIL reset_start_err: got %b%b want 00", a_start, a_err); end
        n_cmp++; if (a_psize !== 6'd0 || a_dsize !== 6'd0) begin n_fail++; $display("FAIL reset_sizes: got %0d/%0d want 0/0", a_psize, a_dsize); end
        n_cmp++; if (a_wdata !== 32'd0 || a_imem_addr !== 5'd0 || a_dmem_addr !== 5'd0) begin n_fail++; $display("FAIL reset_data_addr: got %0h/%0d/%0d want 0/0/0", a_wdata, a_imem_addr, a_dmem_addr); end
        n_cmp++; if (a_ready !== 1'b1 || a_busy !== 1'b1) begin n_fail++; $display("FAIL reset_ready_busy: got %b%b want 11", a_ready, a_busy); end
        rst_n = 1;
        clear_logs();
    endtask

    task automatic test_load_run();
        do_reset();
        for (int i = 0; i < 24; i++) send_a(32'h1000 + i, i == 23);
        n_cmp++; if (a_state !== 3'd1) begin n_fail++; $display("FAIL load_to_d: got %0d want 1", a_state); end
        for (int j = 0; j < 7; j++) begin
            if (j == 6) begin
                n_cmp++; if (a_start !== 1'b0) begin n_fail++; $display("FAIL start_early: got %b want 0", a_start); end
            end
            send_a(32'h2000 + j, j == 6);
        end
        n_cmp++; if (a_dmem_we !== 1'b1 || a_dmem_addr !== 5'd6 || a_wdata !== 32'h2006) begin n_fail++; $display("FAIL last_dwrite: got %b/%0d/%0h want 1/6/2006", a_dmem_we, a_dmem_addr, a_wdata); end
        n_cmp++; if (a_start !== 1'b1 || a_state !== 3'd3) begin n_fail++; $display("FAIL auto_start: got %b/%0d want 1/3", a_start, a_state); end
        step(); step();
        n_cmp++; if (a_icnt !== 24 || a_dcnt !== 7) begin n_fail++; $display("FAIL strobe_counts: got %0d/%0d want 24/7", a_icnt, a_dcnt); end
        for (int i = 0; i < 24; i++) begin
            n_cmp++; if (a_iaddr[i] !== 5'(i) || a_idata[i] !== 32'h1000 + i) begin n_fail++; $display("FAIL imem_word%0d: got %0d/%0h want %0d/%0h", i, a_iaddr[i], a_idata[i], i, 32'h1000 + i); end
        end
        for (int j = 0; j < 7; j++) begin
            n_cmp++; if (a_daddr[j] !== 5'(j) || a_ddata[j] !== 32'h2000 + j) begin n_fail++; $display("FAIL dmem_word%0d: got %0d/%0h want %0d/%0h", j, a_daddr[j], a_ddata[j], j, 32'h2000 + j); end
        end
        n_cmp++; if (a_psize !== 6'd24 || a_dsize !== 6'd7) begin n_fail++; $display("FAIL sizes: got %0d/%0d want 24/7", a_psize, a_dsize); end
        n_cmp++; if (a_both !== 1'b0 || a_first_d_cyc !== a_last_i_cyc + 1) begin n_fail++; $display("FAIL region_switch: both=%b dcyc=%0d want 0/%0d", a_both, a_first_d_cyc, a_last_i_cyc + 1); end
        n_cmp++; if (a_start !== 1'b1 || a_busy !== 1'b1) begin n_fail++; $display("FAIL run_hold: got %b/%b want 1/1", a_start, a_busy); end
    endtask

    task automatic test_proc_end();
        a_end = 1; step(); a_end = 0;
        n_cmp++; if (a_state !== 3'd4 || a_start !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL done: got %0d/%b/%b want 4/0/0", a_state, a_start, a_busy); end
        n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL done_ready: got %b want 0", a_ready); end
        a_valid = 1; a_data = 32'hDEAD; a_last = 1;
        step(); step(); step();
        a_valid = 0; a_last = 0;
        step();
        n_cmp++; if (a_icnt !== 24 || a_dcnt !== 7) begin n_fail++; $display("FAIL done_no_write: got %0d/%0d want 24/7", a_icnt, a_dcnt); end
        n_cmp++; if (a_psize !== 6'd24 || a_dsize !== 6'd7 || a_state !== 3'd4) begin n_fail++; $display("FAIL done_hold: got %0d/%0d/%0d want 24/7/4", a_psize, a_dsize, a_state); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_a(32'd1, 0); send_a(32'd2, 1);
        send_a(32'd3, 0); send_a(32'd4, 0); send_a(32'd5, 0);
        n_cmp++; if (a_dsize !== 6'd3 || a_state !== 3'd1) begin n_fail++; $display("FAIL pre_abort: got %0d/%0d want 3/1", a_dsize, a_state); end
        #2 rst_n = 0;
        #1;
        n_cmp++; if (a_state !== 3'd0 || a_psize !== 6'd0 || a_dsize !== 6'd0) begin n_fail++; $display("FAIL abort: got %0d/%0d/%0d want 0/0/0", a_state, a_psize, a_dsize); end
        n_cmp++; if (a_imem_we !== 1'b0 || a_dmem_we !== 1'b0) begin n_fail++; $display("FAIL abort_we: got %b%b want 00", a_imem_we, a_dmem_we); end
        step();
        rst_n = 1;
        clear_logs();
        send_a(32'hAA, 1); send_a(32'hBB, 1);
        step(); step();
        n_cmp++; if (a_icnt !== 1 || a_iaddr[0] !== 5'd0 || a_idata[0] !== 32'hAA) begin n_fail++; $display("FAIL reload_i: got %0d/%0d/%0h want 1/0/aa", a_icnt, a_iaddr[0], a_idata[0]); end
        n_cmp++; if (a_dcnt !== 1 || a_daddr[0] !== 5'd0 || a_state !== 3'd3) begin n_fail++; $display("FAIL reload_d: got %0d/%0d/%0d want 1/0/3", a_dcnt, a_daddr[0], a_state); end
    endtask

    task automatic test_go();
        do_reset();
        b_go = 1; step(); b_go = 0;
        n_cmp++; if (b_state !== 3'd0) begin n_fail++; $display("FAIL go_ignored: got %0d want 0", b_state); end
        send_b(32'd11, 0); send_b(32'd12, 1); send_b(32'd13, 1);
        n_cmp++; if (b_state !== 3'd2 || b_start !== 1'b0 || b_busy !== 1'b1) begin n_fail++; $display("FAIL wait_go: got %0d/%b/%b want 2/0/1", b_state, b_start, b_busy); end
        b_end = 1; step(); b_end = 0;
        step();
        n_cmp++; if (b_state !== 3'd2 || b_start !== 1'b0) begin n_fail++; $display("FAIL end_ignored: got %0d/%b want 2/0", b_state, b_start); end
        b_go = 1; step(); b_go = 0;
        n_cmp++; if (b_state !== 3'd3 || b_start !== 1'b1) begin n_fail++; $display("FAIL go_run: got %0d/%b want 3/1", b_state, b_start); end
        n_cmp++; if (b_psize !== 3'd2 || b_dsize !== 3'd1 || b_both !== 1'b0) begin n_fail++; $display("FAIL go_sizes: got %0d/%0d/%b want 2/1/0", b_psize, b_dsize, b_both); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) send_b(32'h50 + i, 0);
        n_cmp++; if (b_state !== 3'd5 || b_err !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_state: got %0d/%b/%b want 5/1/0", b_state, b_err, b_ready); end
        n_cmp++; if (b_imem_we !== 1'b0 || b_psize !== 3'd4 || b_start !== 1'b0) begin n_fail++; $display("FAIL ovf_nowrite: got %b/%0d/%b want 0/4/0", b_imem_we, b_psize, b_start); end
        step();
        n_cmp++; if (b_icnt !== 4 || b_idata[3] !== 32'h53 || b_busy !== 1'b0) begin n_fail++; $display("FAIL ovf_count: got %0d/%0h/%b want 4/53/0", b_icnt, b_idata[3], b_busy); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (b_iaddr[i] !== 2'(i)) begin n_fail++; $display("FAIL ovf_addr%0d: got %0d want %0d", i, b_iaddr[i], i); end
        end
        b_go = 1; b_end = 1; b_valid = 1; b_last = 1;
        step(); step();
        b_go = 0; b_end = 0; b_valid = 0; b_last = 0;
        n_cmp++; if (b_state !== 3'd5 || b_err !== 1'b1 || b_start !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky: got %0d/%b/%b want 5/1/0", b_state, b_err, b_start); end
    endtask

    task automatic test_exact_fill();
        do_reset();
        for (int i = 0; i < 4; i++) send_b(32'h60 + i, i == 3);
        n_cmp++; if (b_state !== 3'd1 || b_err !== 1'b0 || b_psize !== 3'd4) begin n_fail++; $display("FAIL fill_i: got %0d/%b/%0d want 1/0/4", b_state, b_err, b_psize); end
        send_b(32'h70, 1);
        n_cmp++; if (b_state !== 3'd2 || b_err !== 1'b0 || b_dsize !== 3'd1) begin n_fail++; $display("FAIL fill_d: got %0d/%b/%0d want 2/0/1", b_state, b_err, b_dsize); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        n_cmp++; if (a_chk_sum !== 32'd0) begin n_fail++; $display("FAIL chk_reset: got %0h want 0", a_chk_sum); end
        a_chk_exp = 32'd13;
        send_a(32'd10, 1); send_a(32'hFFFF_FFF6, 0); send_a(32'd13, 1);
        n_cmp++; if (a_state !== 3'd3 || a_err !== 1'b0 || a_chk_sum !== 32'd13) begin n_fail++; $display("FAIL chk_ok: got %0d/%b/%0h want 3/0/d", a_state, a_err, a_chk_sum); end
        do_reset();
        a_chk_exp = 32'd14;
        send_a(32'd10, 1); send_a(32'hFFFF_FFF6, 0); send_a(32'd13, 1);
        n_cmp++; if (a_state !== 3'd5 || a_err !== 1'b1 || a_start !== 1'b0) begin n_fail++; $display("FAIL chk_bad: got %0d/%b/%b want 5/1/0", a_state, a_err, a_start); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_run();
        test_proc_end();
        test_mid_reset();
        test_go();
        test_overflow();
        test_exact_fill();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
